pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder that succeeds the single-bit full adders. It splits a WIDTH-bit add into STAGES equal slices and computes one slice per register stage, with the carry passed between stages. This gives a fixed latency and one result per clock at full throughput. A valid/ready handshake on both sides lets it sit between streaming producers and consumers in the datapath.

## Interface
- WIDTH, 32, operand/sum width in bits; must be ≥ 1.
- STAGES, 4, number of pipeline stages; must be ≥ 1 and divide WIDTH exactly; slice width SW = WIDTH/STAGES.
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  a/b/cin carry a valid operation.
- in_ready  output  1  adder accepts an operation this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry in.
- out_valid  output  1  sum/cout/ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  unsigned carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage k (0..STAGES-1) adds slice bits [k*SW +: SW] of its held operands plus the incoming carry. Stage 0 uses cin as its incoming carry.
- Each stage register holds:
  - the sum bits already computed;
  - the not-yet-added upper operand bits, so inputs are skewed and never re-read;
  - the slice carry-out;
  - a valid bit.
- The last stage also registers the carry into its MSB, so ovf can be formed.
- Slice arithmetic is an SW-bit ripple of 1-bit full-adder cells: s = x^y^c, c' = x&y | (x^y)&c.
- Global advance: adv = !out_valid | out_ready. When adv=1, every stage loads from its predecessor, and stage 0 loads from the inputs with valid = in_valid. When adv=0, all stages hold.
- in_ready = adv (combinational from out_valid/out_ready, no dependence on in_valid).
- Transfers occur on clock edges where valid & ready are both high, on each side independently.
- Bubbles propagate as valid=0 stages. Bubbles are not compressed; this is a simple stalling pipeline.
- Once out_valid is high, sum/cout/ovf stay stable until the result is accepted.

## Timing
- Latency: an operation accepted at edge N appears with out_valid=1 after edge N+STAGES, provided no stall occurs. Each stall cycle adds one cycle.
- Throughput: 1 op/clk while out_ready=1.
- Reset (rst_n=0, asynchronous):
  - all valid bits, data, and carries clear immediately;
  - out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Reset mid-operation: all in-flight operations are discarded, with no partial result output. The first edge after deassertion may accept new input.
- Full pipeline with out_ready=0: in_ready=0 and nothing is lost or duplicated.
- Simultaneous accept of a result and a new input on the same edge is legal and required at full rate.
- Wrap-around: the sum is mod 2^WIDTH. 0xFFFFFFFF+1 gives sum 0, cout=1.
- STAGES=1: a single register, latency 1.
- STAGES=WIDTH: one bit per stage.

## Structure
- Shared package: the default WIDTH/STAGES constants, and a function computing ovf from the MSB carries.
- One natural sub-module, adder_slice: combinational SW-bit ripple adder (ports x, y, ci, s, co, c_msb), instantiated once per stage by a generate loop.
- Stage registers and the skew registers live in pipelined_adder.
- Static assertion: WIDTH % STAGES == 0.

## Test plan
- Reset: hold rst_n=0, drive in_valid=1 → out_valid=0, sum=0, in_ready=1. Deassert, send a=5, b=7, cin=0 → after 4 cycles sum=12, cout=0, ovf=0.
- Carry across all slices: a=0xFFFFFFFF, b=0, cin=1 → sum=0x00000000, cout=1, ovf=0. Then a=0x7FFFFFFF, b=1, cin=0 → sum=0x80000000, cout=0, ovf=1.
- Streaming: 100 back-to-back random ops with out_ready=1 → 100 results in order, matching a reference model, one per clk, first result 4 cycles after the first accept.
- Backpressure: fill the pipeline, then set out_ready=0 for 10 cycles → in_ready=0, output held stable, no drops. Release → remaining results emerge in order with no duplicates.
- Random in_valid/out_ready (50% each) with 1000 ops → scoreboard exact match and ordering preserved.
- Async reset with 3 ops in flight → out_valid falls immediately, none of the 3 ever appear, and the next op after release completes correctly.
- Parameter sweep: WIDTH=8/STAGES=1, WIDTH=8/STAGES=8, and WIDTH=64/STAGES=4 → exhaustive (8-bit) or random (64-bit) checks pass, with latency equal to STAGES.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipelined_adder_pkg : shared defaults and overflow helper           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pipelined_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Signed overflow from the carries entering and leaving the MSB.
  function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_slice.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | adder_slice : combinational SW-bit ripple of 1-bit full adders      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] x_i,
  input  logic [SW-1:0] y_i,
  input  logic          ci_i,
  output logic [SW-1:0] s_o,
  output logic          co_o,
  output logic          c_msb_o
);

  always_comb begin
    logic carry;
    s_o     = '0;
    c_msb_o = ci_i;
    carry   = ci_i;
    for (int i = 0; i < SW; i++) begin
      if (i == SW - 1) c_msb_o = carry;
      s_o[i] = x_i[i] ^ y_i[i] ^ carry;
      carry  = (x_i[i] & y_i[i]) | ((x_i[i] ^ y_i[i]) & carry);
    end
    co_o = carry;
  end

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipelined_adder : stalling valid/ready pipelined ripple-carry adder |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam int SW = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: STAGES must divide WIDTH exactly");
  end

  // as_q holds the not-yet-added A bits in its low part and the finished
  // sum slices in its high part; both shift right by SW per stage, so the
  // last stage's register is exactly the sum.
  logic [WIDTH-1:0] as_q [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic             carry_q [STAGES];
  logic             valid_q [STAGES];
  logic             cmsb_q;

  logic [WIDTH-1:0] as_src [STAGES];
  logic [WIDTH-1:0] b_src  [STAGES];
  logic [WIDTH-1:0] as_d   [STAGES];
  logic [WIDTH-1:0] b_d    [STAGES];
  logic             ci_src [STAGES];
  logic             v_src  [STAGES];
  logic             co     [STAGES];
  logic             cm     [STAGES];
  logic             adv;

  assign adv = !valid_q[STAGES-1] || out_ready_i;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW-1:0]    s;
    logic [WIDTH-1:0] ins;

    if (k == 0) begin : g_first
      assign as_src[k] = a_i;
      assign b_src[k]  = b_i;
      assign ci_src[k] = cin_i;
      assign v_src[k]  = in_valid_i;
    end else begin : g_next
      assign as_src[k] = as_q[k-1];
      assign b_src[k]  = b_q[k-1];
      assign ci_src[k] = carry_q[k-1];
      assign v_src[k]  = valid_q[k-1];
    end

    adder_slice #(.SW(SW)) u_slice (
      .x_i     (as_src[k][SW-1:0]),
      .y_i     (b_src[k][SW-1:0]),
      .ci_i    (ci_src[k]),
      .s_o     (s),
      .co_o    (co[k]),
      .c_msb_o (cm[k])
    );

    always_comb begin
      ins = '0;
      ins[WIDTH-1 -: SW] = s;
    end

    assign as_d[k] = (as_src[k] >> SW) | ins;
    assign b_d[k]  = b_src[k] >> SW;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        as_q[k]    <= '0;
        b_q[k]     <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
      end
      cmsb_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        as_q[k]    <= as_d[k];
        b_q[k]     <= b_d[k];
        carry_q[k] <= co[k];
        valid_q[k] <= v_src[k];
      end
      cmsb_q <= cm[STAGES-1];
    end
  end

  assign in_ready_o  = adv;
  assign out_valid_o = valid_q[STAGES-1];
  assign sum_o       = as_q[STAGES-1];
  assign cout_o      = carry_q[STAGES-1];
  assign ovf_o       = signed_ovf(cmsb_q, carry_q[STAGES-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipelined_adder : randomized bench with arithmetic reference     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_pipelined_adder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf;
  logic [31:0] sum;

  logic        sw_valid = 1'b0, sw_ordy = 1'b1, sw_c = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [63:0] a64 = '0, b64 = '0;
  logic        r1_ir, r1_v, r1_co, r1_ov, r8_ir, r8_v, r8_co, r8_ov, r64_ir, r64_v, r64_co, r64_ov;
  logic [7:0]  r1_s, r8_s;
  logic [63:0] r64_s;

  int total = 0;
  int bad   = 0;
  logic [65:0] sb [$];

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(32), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .cout_o(cout), .ovf_o(ovf));

  pipelined_adder #(.WIDTH(8), .STAGES(1)) dut_8x1 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(sw_valid), .in_ready_o(r1_ir),
    .a_i(a8), .b_i(b8), .cin_i(sw_c), .out_valid_o(r1_v), .out_ready_i(sw_ordy),
    .sum_o(r1_s), .cout_o(r1_co), .ovf_o(r1_ov));

  pipelined_adder #(.WIDTH(8), .STAGES(8)) dut_8x8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(sw_valid), .in_ready_o(r8_ir),
    .a_i(a8), .b_i(b8), .cin_i(sw_c), .out_valid_o(r8_v), .out_ready_i(sw_ordy),
    .sum_o(r8_s), .cout_o(r8_co), .ovf_o(r8_ov));

  pipelined_adder #(.WIDTH(64), .STAGES(4)) dut_64x4 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(sw_valid), .in_ready_o(r64_ir),
    .a_i(a64), .b_i(b64), .cin_i(sw_c), .out_valid_o(r64_v), .out_ready_i(sw_ordy),
    .sum_o(r64_s), .cout_o(r64_co), .ovf_o(r64_ov));

  // Reference: {ovf, cout, sum} of a w-bit add using plain wide arithmetic.
  function automatic logic [65:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic c, input int w);
    logic [64:0] t;
    logic [63:0] m, s;
    logic        co, ov;
    t  = {1'b0, x} + {1'b0, y} + {64'd0, c};
    m  = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    s  = t[63:0] & m;
    co = t[w];
    ov = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {ov, co, s};
  endfunction

  // One clock of the main DUT: drive, observe handshakes just before the edge.
  task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                     input logic ic, input logic ordy,
                     output logic acc_in, output logic acc_out,
                     output logic [31:0] os, output logic oc, output logic oo);
    in_valid = iv; a = ia; b = ib; cin = ic; out_ready = ordy;
    #1;
    acc_in = iv & in_ready;
    acc_out = out_valid & ordy;
    os = sum; oc = cout; oo = ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic ai, ao, oc, oo;
    logic [31:0] os;
    int lat;
    rst_n = 1'b0; in_valid = 1'b1; a = 32'd5; b = 32'd7; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    total++;
    if ({sum, cout, ovf} !== 34'd0) begin bad++; $display("FAIL reset_outputs: got %h/%b/%b want 0", sum, cout, ovf); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    cyc(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, ai, ao, os, oc, oo);
    total++;
    if (ai !== 1'b1) begin bad++; $display("FAIL first_accept: got %b want 1", ai); end
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, ai, ao, os, oc, oo);
      lat++;
    end
    total++;
    if (lat != S) begin bad++; $display("FAIL latency: got %0d want %0d", lat, S); end
    total++;
    if ({ovf, cout, sum} !== {2'b00, 32'd12}) begin
      bad++; $display("FAIL sum_5_7: got %b/%b/%h want 0/0/0000000c", ovf, cout, sum);
    end
    cyc(1'b0, '0, '0, 1'b0, 1'b1, ai, ao, os, oc, oo);
  endtask

  task automatic test_carry();
    logic ai, ao, oc, oo;
    logic [31:0] os;
    logic [33:0] got [2];
    int n = 0;
    cyc(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, ai, ao, os, oc, oo);
    cyc(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b1, ai, ao, os, oc, oo);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, ai, ao, os, oc, oo);
      if (ao) begin
        if (n < 2) got[n] = {oo, oc, os};
        n++;
      end
    end
    total++;
    if (n != 2) begin bad++; $display("FAIL carry_count: got %0d want 2", n); end
    total++;
    if (got[0] !== {2'b01, 32'h0000_0000}) begin bad++; $display("FAIL carry_all_slices: got %h want 100000000", got[0]); end
    total++;
    if (got[1] !== {2'b10, 32'h8000_0000}) begin bad++; $display("FAIL signed_ovf: got %h want 280000000", got[1]); end
  endtask

  task automatic test_stream();
    logic ai, ao, oc, oo;
    logic [31:0] os, ra, rb;
    logic rc;
    logic [65:0] e;
    int first = -1, last = -1, n = 0;
    for (int i = 0; i < 120; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      cyc(i < 100, ra, rb, rc, 1'b1, ai, ao, os, oc, oo);
      if (ai) sb.push_back(ref_add({32'd0, ra}, {32'd0, rb}, rc, 32));
      if (ao) begin
        if (first < 0) first = i;
        last = i; n++;
        e = sb.pop_front();
        total++;
        if ({oo, oc, 32'd0, os} !== e) begin bad++; $display("FAIL stream_data: got %h want %h", {oo, oc, 32'd0, os}, e); end
      end
    end
    total++;
    if (first != S || last != S + 99 || n != 100) begin
      bad++; $display("FAIL stream_timing: got first=%0d last=%0d n=%0d want %0d/%0d/100", first, last, n, S, S + 99);
    end
  endtask

  task automatic test_backpressure();
    logic ai, ao, oc, oo;
    logic [31:0] os;
    logic [33:0] held;
    logic [65:0] e;
    int acc = 0, n = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b0, 1'b0, ai, ao, os, oc, oo);
      if (ai) begin sb.push_back(ref_add({32'd0, a}, {32'd0, b}, 1'b0, 32)); acc++; end
    end
    total++;
    if (acc != S) begin bad++; $display("FAIL bp_fill: got %0d accepted want %0d", acc, S); end
    held = {ovf, cout, sum};
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, ai, ao, os, oc, oo);
      total++;
      if (ai !== 1'b0 || out_valid !== 1'b1 || {oo, oc, os} !== held) begin
        bad++; $display("FAIL bp_hold: got acc=%b v=%b out=%h want 0/1/%h", ai, out_valid, {oo, oc, os}, held);
      end
    end
    for (int i = 0; i < 30; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, ai, ao, os, oc, oo);
      if (ao) begin
        n++;
        e = (sb.size() > 0) ? sb.pop_front() : '1;
        total++;
        if ({oo, oc, 32'd0, os} !== e) begin bad++; $display("FAIL bp_drain: got %h want %h", {oo, oc, 32'd0, os}, e); end
      end
    end
    total++;
    if (n != S || sb.size() != 0) begin bad++; $display("FAIL bp_count: got %0d left=%0d want %0d/0", n, sb.size(), S); end
  endtask

  task automatic test_random();
    logic ai, ao, oc, oo, rc;
    logic [31:0] os, ra, rb;
    logic [65:0] e;
    int sent = 0, outs = 0;
    for (int i = 0; i < 20000 && outs < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      cyc((sent < 1000) && ($urandom_range(0, 1) == 1), ra, rb, rc, 1'($urandom_range(0, 1)),
          ai, ao, os, oc, oo);
      if (ai) begin sb.push_back(ref_add({32'd0, ra}, {32'd0, rb}, rc, 32)); sent++; end
      if (ao) begin
        outs++;
        e = (sb.size() > 0) ? sb.pop_front() : '1;
        total++;
        if ({oo, oc, 32'd0, os} !== e) begin bad++; $display("FAIL random_data: got %h want %h", {oo, oc, 32'd0, os}, e); end
      end
    end
    total++;
    if (outs != 1000 || sb.size() != 0) begin bad++; $display("FAIL random_count: got %0d left=%0d want 1000/0", outs, sb.size()); end
  endtask

  task automatic test_async_reset();
    logic ai, ao, oc, oo;
    logic [31:0] os;
    logic [65:0] e;
    int n = 0;
    for (int i = 0; i < 3; i++) cyc(1'b1, $urandom, $urandom, 1'b1, 1'b0, ai, ao, os, oc, oo);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, ai, ao, os, oc, oo);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL ar_inflight: got out_valid=%b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || {sum, cout, ovf} !== 34'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL ar_immediate: got v=%b out=%h rdy=%b want 0/0/1", out_valid, {sum, cout, ovf}, in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, ai, ao, os, oc, oo);
      if (ao) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL ar_discard: got %0d stale results want 0", n); end
    cyc(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, ai, ao, os, oc, oo);
    e = ref_add(64'h8000_0000, 64'h8000_0000, 1'b1, 32);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b1, ai, ao, os, oc, oo);
      if (ao) begin
        n++;
        total++;
        if ({oo, oc, 32'd0, os} !== e) begin bad++; $display("FAIL ar_next_op: got %h want %h", {oo, oc, 32'd0, os}, e); end
      end
    end
    total++;
    if (n != 1) begin bad++; $display("FAIL ar_next_count: got %0d want 1", n); end
  endtask

  task automatic test_sweep();
    logic [65:0] q1 [$], q8 [$], q64 [$];
    logic [65:0] e;
    int f1 = -1, f8 = -1, f64 = -1;
    for (int i = 0; i < 65536 + 12; i++) begin
      sw_valid = (i < 65536);
      a8 = 8'(i); b8 = 8'(i >> 8); sw_c = 1'($urandom_range(0, 1));
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      sw_ordy = 1'b1;
      #1;
      if (sw_valid) begin
        q1.push_back(ref_add({56'd0, a8}, {56'd0, b8}, sw_c, 8));
        q8.push_back(ref_add({56'd0, a8}, {56'd0, b8}, sw_c, 8));
        q64.push_back(ref_add(a64, b64, sw_c, 64));
      end
      if (r1_v) begin
        if (f1 < 0) f1 = i;
        e = (q1.size() > 0) ? q1.pop_front() : '1;
        total++;
        if ({r1_ov, r1_co, 56'd0, r1_s} !== e) begin bad++; $display("FAIL sweep_8x1: got %h want %h", {r1_ov, r1_co, 56'd0, r1_s}, e); end
      end
      if (r8_v) begin
        if (f8 < 0) f8 = i;
        e = (q8.size() > 0) ? q8.pop_front() : '1;
        total++;
        if ({r8_ov, r8_co, 56'd0, r8_s} !== e) begin bad++; $display("FAIL sweep_8x8: got %h want %h", {r8_ov, r8_co, 56'd0, r8_s}, e); end
      end
      if (r64_v) begin
        if (f64 < 0) f64 = i;
        e = (q64.size() > 0) ? q64.pop_front() : '1;
        total++;
        if ({r64_ov, r64_co, r64_s} !== e) begin bad++; $display("FAIL sweep_64x4: got %h want %h", {r64_ov, r64_co, r64_s}, e); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (f1 != 1 || f8 != 8 || f64 != 4) begin
      bad++; $display("FAIL sweep_latency: got %0d/%0d/%0d want 1/8/4", f1, f8, f64);
    end
    total++;
    if (q1.size() != 0 || q8.size() != 0 || q64.size() != 0) begin
      bad++; $display("FAIL sweep_leftover: got %0d/%0d/%0d want 0/0/0", q1.size(), q8.size(), q64.size());
    end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_stream();
    test_backpressure();
    test_random();
    test_async_reset();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
